regfile_wb_ctrl: RTL and testbench

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl.sv | 134 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: arbitrates in-order ALU writes against a small
// long-latency (LSU) writeback FIFO. Optional pending-register scoreboard via WB_SCOREBOARD_EN.
module regfile_wb_ctrl #(
  parameter int REG_NUM    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_wa,
  input  logic [31:0] alu_wd,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_wa,
  input  logic [31:0] lsu_wd,
  output logic        lsu_ready,
  output logic        stall_req,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [4:0]    fifo_wa_q [FIFO_DEPTH];
  logic [31:0]   fifo_wd_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          we_q, we_d;
  logic          lsu_src_q, lsu_src_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic          full, empty, push, pop, alu_wr;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  // Ready/stall look at pre-pop occupancy, so a full FIFO never pushes even while popping.
  assign lsu_ready = !cpu_rst && !full;
  assign stall_req = !cpu_rst && full;
  assign push      = lsu_valid && lsu_ready && (lsu_wa != 5'd0);
  assign alu_wr    = alu_valid && (alu_wa != 5'd0);
  assign pop       = !alu_wr && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    we_d      = 1'b0;
    lsu_src_d = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (alu_wr) begin
      we_d = 1'b1;
      wa_d = alu_wa;
      wd_d = alu_wd;
    end else if (pop) begin
      we_d      = 1'b1;
      lsu_src_d = 1'b1;
      wa_d      = fifo_wa_q[rd_ptr_q];
      wd_d      = fifo_wd_q[rd_ptr_q];
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      lsu_src_q <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      lsu_src_q <= lsu_src_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge cpu_clk_50M) begin
    if (push) begin
      fifo_wa_q[wr_ptr_q] <= lsu_wa;
      fifo_wd_q[wr_ptr_q] <= lsu_wd;
    end
  end

  assign we = we_q;
  assign wa = wa_q;
  assign wd = wd_q;

`ifdef WB_SCOREBOARD_EN
  logic [REG_NUM-1:0] pend_q, pend_d;

  // Clear lands once the LSU write is on the output; a same-cycle issue re-sets the bit.
  always_comb begin
    pend_d = pend_q;
    if (we_q && lsu_src_q) pend_d[wa_q] = 1'b0;
    if (iss_valid && (iss_wa != 5'd0)) pend_d[iss_wa] = 1'b1;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign busy1 = !cpu_rst && pend_q[ra1];
  assign busy2 = !cpu_rst && pend_q[ra2];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_wa, ra1, ra2, lsu_src_q};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed, table-driven bench for regfile_wb_ctrl; scoreboard checks follow WB_SCOREBOARD_EN.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, iss_valid;
  logic [4:0]  alu_wa, lsu_wa, iss_wa, ra1, ra2;
  logic [31:0] alu_wd, lsu_wd;
  logic        lsu_ready, stall_req, busy1, busy2, we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_ctrl #(.REG_NUM(32), .FIFO_DEPTH(2)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd),
    .lsu_ready(lsu_ready), .stall_req(stall_req),
    .iss_valid(iss_valid), .iss_wa(iss_wa),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
    .we(we), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic        ready;
    logic        stall;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_wa = '0; lsu_wd = '0;
    iss_valid = 1'b0; iss_wa = '0;
  endtask

  initial begin
    // inputs applied in cycle i; ready/stall checked in cycle i, we/wa/wd after the edge
    vecs[0]  = '{1'b1, 5'd3,  32'h1234_5678, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd3,  32'h1234_5678};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd3,  32'h1234_5678};
    vecs[2]  = '{1'b1, 5'd4,  32'hA,         1'b1, 5'd5,  32'hB,    1'b1, 1'b0, 1'b1, 5'd4,  32'hA};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd5,  32'hB};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd5,  32'hB};
    vecs[5]  = '{1'b1, 5'd1,  32'h11,        1'b1, 5'd6,  32'h66,   1'b1, 1'b0, 1'b1, 5'd1,  32'h11};
    vecs[6]  = '{1'b1, 5'd2,  32'h22,        1'b1, 5'd7,  32'h77,   1'b1, 1'b0, 1'b1, 5'd2,  32'h22};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd8,  32'h88,   1'b0, 1'b1, 1'b1, 5'd6,  32'h66};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd8,  32'h88,   1'b1, 1'b0, 1'b1, 5'd7,  32'h77};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd8,  32'h88};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd8,  32'h88};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'hDEAD, 1'b1, 1'b0, 1'b0, 5'd8,  32'h88};
    vecs[12] = '{1'b1, 5'd0,  32'hBEEF,      1'b1, 5'd0,  32'hCAFE, 1'b1, 1'b0, 1'b0, 5'd8,  32'h88};
    vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd8,  32'h88};
    vecs[14] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  32'h99,   1'b1, 1'b0, 1'b0, 5'd8,  32'h88};
    vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'hAA,   1'b1, 1'b0, 1'b1, 5'd9,  32'h99};
    vecs[16] = '{1'b1, 5'd11, 32'hB1,        1'b1, 5'd12, 32'hC2,   1'b1, 1'b0, 1'b1, 5'd11, 32'hB1};
    vecs[17] = '{1'b1, 5'd13, 32'hD3,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd13, 32'hD3};
    vecs[18] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd10, 32'hAA};
    vecs[19] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd12, 32'hC2};
    vecs[20] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd12, 32'hC2};

    idle_inputs();
    ra1 = 5'd7;
    ra2 = 5'd9;
    rst = 1'b1;

    // reset: outputs quiet during reset, request presented in reset cycle is dropped
    repeat (2) step();
    lsu_valid = 1'b1; lsu_wa = 5'd5; lsu_wd = 32'h5555;
    #1;
    chk("rst_ready", 32'(lsu_ready), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("post_rst_we", 32'(we), 32'd0);
    chk("post_rst_wa", 32'(wa), 32'd0);
    chk("post_rst_wd", wd, 32'd0);
    chk("post_rst_ready", 32'(lsu_ready), 32'd1);
    chk("post_rst_stall", 32'(stall_req), 32'd0);
    step();
    chk("post_rst_dropped_we", 32'(we), 32'd0);

    for (int i = 0; i < 21; i++) begin
      alu_valid = vecs[i].av; alu_wa = vecs[i].awa; alu_wd = vecs[i].awd;
      lsu_valid = vecs[i].lv; lsu_wa = vecs[i].lwa; lsu_wd = vecs[i].lwd;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(lsu_ready), 32'(vecs[i].ready));
      chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'(vecs[i].stall));
      step();
      chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].we));
      chk($sformatf("v%0d_wa", i), 32'(wa), 32'(vecs[i].wa));
      chk($sformatf("v%0d_wd", i), wd, vecs[i].wd);
    end
    idle_inputs();

    // reset with two entries queued: contents are lost, no write follows
    alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = 32'h1;
    lsu_valid = 1'b1; lsu_wa = 5'd14; lsu_wd = 32'hE1;
    step();
    alu_wa = 5'd2; alu_wd = 32'h2;
    lsu_wa = 5'd15; lsu_wd = 32'hF1;
    step();
    idle_inputs();
    #1;
    chk("mid_full_stall", 32'(stall_req), 32'd1);
    rst = 1'b1;
    lsu_valid = 1'b1; lsu_wa = 5'd16; lsu_wd = 32'h16;
    #1;
    chk("mid_rst_ready", 32'(lsu_ready), 32'd0);
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    step();
    rst = 1'b0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("mid_c%0d_we", c), 32'(we), 32'd0);
      chk($sformatf("mid_c%0d_ready", c), 32'(lsu_ready), 32'd1);
      chk($sformatf("mid_c%0d_busy", c), 32'({busy1, busy2}), 32'd0);
      step();
    end
    chk("mid_rst_wa", 32'(wa), 32'd0);

`ifdef WB_SCOREBOARD_EN
    iss_valid = 1'b1; iss_wa = 5'd7;
    #1;
    chk("sb_iss_same_cycle_busy1", 32'(busy1), 32'd0);
    step();
    idle_inputs();
    chk("sb_iss_busy1", 32'(busy1), 32'd1);
    chk("sb_iss_busy2", 32'(busy2), 32'd0);
    alu_valid = 1'b1; alu_wa = 5'd7; alu_wd = 32'h70;
    step();
    idle_inputs();
    chk("sb_alu_we", 32'(we), 32'd1);
    chk("sb_alu_keeps_busy", 32'(busy1), 32'd1);
    step();
    chk("sb_alu_keeps_busy_after", 32'(busy1), 32'd1);
    lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 32'h77;
    step();
    idle_inputs();
    step();
    chk("sb_lsu_we", 32'(we), 32'd1);
    chk("sb_lsu_wa", 32'(wa), 32'd7);
    chk("sb_lsu_we_cycle_busy", 32'(busy1), 32'd1);
    step();
    chk("sb_lsu_cleared", 32'(busy1), 32'd0);
    iss_valid = 1'b1; iss_wa = 5'd7;
    step();
    idle_inputs();
    chk("sb_reiss_busy", 32'(busy1), 32'd1);
    lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 32'h78;
    step();
    idle_inputs();
    step();
    iss_valid = 1'b1; iss_wa = 5'd7;
    chk("sb_coll_we", 32'(we), 32'd1);
    step();
    idle_inputs();
    chk("sb_coll_set_wins", 32'(busy1), 32'd1);
    iss_valid = 1'b1; iss_wa = 5'd9;
    step();
    idle_inputs();
    chk("sb_busy2", 32'(busy2), 32'd1);
    ra1 = 5'd0;
    iss_valid = 1'b1; iss_wa = 5'd0;
    step();
    idle_inputs();
    chk("sb_r0_never_busy", 32'(busy1), 32'd0);
`else
    iss_valid = 1'b1; iss_wa = 5'd7;
    step();
    idle_inputs();
    chk("nosb_busy1", 32'(busy1), 32'd0);
    iss_valid = 1'b1; iss_wa = 5'd9;
    step();
    idle_inputs();
    chk("nosb_busy2", 32'(busy2), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
